// File: rtl/matrix_op_engine_pkg.sv
//============================================================================
// Module   : matrix_op_pkg
// Brief    : Op codes and FSM state encoding shared by the matrix op engine.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package matrix_op_pkg;

    typedef enum logic [1:0] {
        OP_ADD       = 2'd0,
        OP_SUB       = 2'd1,
        OP_TRANSPOSE = 2'd2,
        OP_SCALE     = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/matrix_op_engine_if.sv
//============================================================================
// Module   : matrix_op_engine_if
// Brief    : Start/busy/done handshake plus operand and result buses.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface matrix_op_engine_if #(
    parameter int SIZE   = 4,
    parameter int LENGTH = 8
);
    logic                          start;
    logic [1:0]                    op;
    logic [SIZE*SIZE*LENGTH-1:0]   first;
    logic [SIZE*SIZE*LENGTH-1:0]   second;
    logic [LENGTH-1:0]             scalar;
    logic                          busy;
    logic                          done;
    logic [SIZE*SIZE*LENGTH-1:0]   result;
    logic                          overflow;

    modport master (
        output start, op, first, second, scalar,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, op, first, second, scalar,
        output busy, done, result, overflow
    );
endinterface

`default_nettype wire

// File: rtl/matrix_op_engine_alu.sv
//============================================================================
// Module   : matrix_elem_alu
// Brief    : Combinational single-element add/sub/pass/scale with overflow.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module matrix_elem_alu
    import matrix_op_pkg::*;
#(
    parameter int LENGTH   = 8,
    parameter int SATURATE = 0
) (
    input  op_e               op,
    input  logic [LENGTH-1:0] a,
    input  logic [LENGTH-1:0] b,
    input  logic [LENGTH-1:0] scalar,
    output logic [LENGTH-1:0] y,
    output logic              ovf
);
    logic [LENGTH:0]     w_sum;
    logic [LENGTH:0]     w_diff;
    logic [2*LENGTH-1:0] w_prod;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_prod = {{LENGTH{1'b0}}, a} * {{LENGTH{1'b0}}, scalar};

    always_comb begin
        y   = a;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                ovf = w_sum[LENGTH];
                y   = (SATURATE != 0 && ovf) ? {LENGTH{1'b1}} : w_sum[LENGTH-1:0];
            end
            OP_SUB: begin
                // MSB of the widened difference is the borrow
                ovf = w_diff[LENGTH];
                y   = (SATURATE != 0 && ovf) ? {LENGTH{1'b0}} : w_diff[LENGTH-1:0];
            end
            OP_SCALE: begin
                ovf = |w_prod[2*LENGTH-1:LENGTH];
                y   = (SATURATE != 0 && ovf) ? {LENGTH{1'b1}} : w_prod[LENGTH-1:0];
            end
            default: begin
                y   = a;
                ovf = 1'b0;
            end
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/matrix_op_engine.sv
//============================================================================
// Module   : matrix_op_engine
// Brief    : Sequential SIZE x SIZE matrix ALU, one element per clock.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module matrix_op_engine
    import matrix_op_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int LENGTH   = 8,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    matrix_op_engine_if.slave  bus
);
    localparam int c_N  = SIZE * SIZE;
    localparam int c_W  = c_N * LENGTH;
    localparam int c_CW = $clog2(SIZE + 1);
    localparam int c_IW = $clog2(c_N + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SIZE - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    op_e               r_op;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic [c_W-1:0]    r_result;
    logic [LENGTH-1:0] r_scalar;
    logic [c_CW-1:0]   r_row;
    logic [c_CW-1:0]   r_col;
    logic              r_overflow;

    logic              w_accept;
    logic              w_last;
    logic [c_IW-1:0]   w_idx;
    logic [c_IW-1:0]   w_tidx;
    logic [LENGTH-1:0] w_a;
    logic [LENGTH-1:0] w_b;
    logic [LENGTH-1:0] w_y;
    logic              w_ovf;

    assign w_last = (r_row == c_LAST) && (r_col == c_LAST);
    assign w_idx  = c_IW'(r_row) * c_IW'(SIZE) + c_IW'(r_col);
    assign w_tidx = c_IW'(r_col) * c_IW'(SIZE) + c_IW'(r_row);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Transpose reads A at the mirrored position; B is only meaningful for add/sub
    always_comb begin
        w_a = (r_op == OP_TRANSPOSE) ? r_a[w_tidx*LENGTH +: LENGTH]
                                     : r_a[w_idx*LENGTH +: LENGTH];
        w_b = r_b[w_idx*LENGTH +: LENGTH];
    end

    matrix_elem_alu #(
        .LENGTH   (LENGTH),
        .SATURATE (SATURATE)
    ) u_alu (
        .op     (r_op),
        .a      (w_a),
        .b      (w_b),
        .scalar (r_scalar),
        .y      (w_y),
        .ovf    (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_scalar   <= '0;
            r_result   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_op       <= op_e'(bus.op);
            r_a        <= bus.first;
            r_b        <= bus.second;
            r_scalar   <= bus.scalar;
            r_row      <= '0;
            r_col      <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_result[w_idx*LENGTH +: LENGTH] <= w_y;
            r_overflow <= r_overflow | w_ovf;
            if (r_col == c_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_matrix_op_engine.sv
//============================================================================
// Module   : tb_matrix_op_engine
// Brief    : Directed bench for matrix_op_engine with a reference model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_matrix_op_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // 2x2 stimulus shared by the wrap and clamp instances, 3x3 separate
    logic        s2_start = 1'b0;
    logic [1:0]  s2_op    = 2'd0;
    logic [31:0] s2_a     = '0;
    logic [31:0] s2_b     = '0;
    logic [7:0]  s2_sc    = '0;
    logic        s3_start = 1'b0;
    logic [1:0]  s3_op    = 2'd0;
    logic [71:0] s3_a     = '0;
    logic [71:0] s3_b     = '0;
    logic [7:0]  s3_sc    = '0;

    matrix_op_engine_if #(.SIZE(2), .LENGTH(8)) if0 ();
    matrix_op_engine_if #(.SIZE(2), .LENGTH(8)) if1 ();
    matrix_op_engine_if #(.SIZE(3), .LENGTH(8)) if3 ();

    assign if0.start = s2_start; assign if0.op = s2_op; assign if0.first = s2_a;
    assign if0.second = s2_b;    assign if0.scalar = s2_sc;
    assign if1.start = s2_start; assign if1.op = s2_op; assign if1.first = s2_a;
    assign if1.second = s2_b;    assign if1.scalar = s2_sc;
    assign if3.start = s3_start; assign if3.op = s3_op; assign if3.first = s3_a;
    assign if3.second = s3_b;    assign if3.scalar = s3_sc;

    matrix_op_engine #(.SIZE(2), .LENGTH(8), .SATURATE(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    matrix_op_engine #(.SIZE(2), .LENGTH(8), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    matrix_op_engine #(.SIZE(3), .LENGTH(8), .SATURATE(0)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

    logic        d_busy [3];
    logic        d_done [3];
    logic        d_ovf  [3];
    logic [71:0] d_res  [3];
    assign d_busy[0] = if0.busy; assign d_done[0] = if0.done; assign d_ovf[0] = if0.overflow;
    assign d_busy[1] = if1.busy; assign d_done[1] = if1.done; assign d_ovf[1] = if1.overflow;
    assign d_busy[2] = if3.busy; assign d_done[2] = if3.done; assign d_ovf[2] = if3.overflow;
    assign d_res[0] = {40'd0, if0.result};
    assign d_res[1] = {40'd0, if1.result};
    assign d_res[2] = if3.result;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Whole-matrix result of one operation, element by element with plain integers
    function automatic logic [72:0] model_op(input int n, input bit sat, input int op,
                                             input logic [71:0] a, input logic [71:0] b,
                                             input int sc);
        logic [71:0] r;
        bit ov;
        int av, bv, v;
        r  = '0;
        ov = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                av = int'(a[8*(i*n+j) +: 8]);
                bv = int'(b[8*(i*n+j) +: 8]);
                case (op)
                    0: begin
                        v = av + bv;
                        if (v > 255) begin ov = 1'b1; v = sat ? 255 : v - 256; end
                    end
                    1: begin
                        v = av - bv;
                        if (v < 0) begin ov = 1'b1; v = sat ? 0 : v + 256; end
                    end
                    2: v = int'(a[8*(j*n+i) +: 8]);
                    default: begin
                        v = av * sc;
                        if (v > 255) begin ov = 1'b1; v = sat ? 255 : v % 256; end
                    end
                endcase
                r[8*(i*n+j) +: 8] = v[7:0];
            end
        end
        return {ov, r};
    endfunction

    // m_cnt: cycles of busy remaining after an accepted start (done on the last)
    int          m_cnt [3];
    logic [72:0] m_mod [3];

    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (rst) begin
                m_cnt[u] <= 0;
                m_mod[u] <= '0;
            end else if (m_cnt[u] > 0) begin
                m_cnt[u] <= m_cnt[u] - 1;
            end else if (u < 2 && s2_start) begin
                m_cnt[u] <= 5;
                m_mod[u] <= model_op(2, u == 1, int'(s2_op), {40'd0, s2_a}, {40'd0, s2_b}, int'(s2_sc));
            end else if (u == 2 && s3_start) begin
                m_cnt[u] <= 10;
                m_mod[u] <= model_op(3, 1'b0, int'(s3_op), s3_a, s3_b, int'(s3_sc));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 3; u++) begin
                check($sformatf("u%0d_busy", u), 72'(d_busy[u]), 72'(m_cnt[u] > 0));
                check($sformatf("u%0d_done", u), 72'(d_done[u]), 72'(m_cnt[u] == 1));
                if (m_cnt[u] <= 1) begin
                    check($sformatf("u%0d_result", u), d_res[u], m_mod[u][71:0]);
                    check($sformatf("u%0d_overflow", u), 72'(d_ovf[u]), 72'(m_mod[u][72]));
                end
            end
        end
    end

    task automatic set2(input int a0, input int a1, input int a2, input int a3,
                        input int b0, input int b1, input int b2, input int b3);
        s2_a = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        s2_b = {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
    endtask

    // Launch one operation and wait (bounded) for done; returns to idle before exit
    task automatic go(input int sel, input int op, input int sc, input int exp_lat);
        int lat;
        if (sel == 0) begin s2_op = op[1:0]; s2_sc = sc[7:0]; s2_start = 1'b1; end
        else          begin s3_op = op[1:0]; s3_sc = sc[7:0]; s3_start = 1'b1; end
        @(posedge clk); #1;
        s2_start = 1'b0;
        s3_start = 1'b0;
        lat = 0;
        while (((sel == 0) ? !if0.done : !if3.done) && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_latency", 72'(lat), 72'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int dones;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        check("rst_busy",   72'(if0.busy), 72'd0);
        check("rst_done",   72'(if0.done), 72'd0);
        check("rst_result", d_res[2], 72'd0);
        check("rst_ovf",    72'(if1.overflow), 72'd0);

        set2(1, 2, 3, 4, 10, 20, 30, 40);
        go(0, 0, 0, 4);
        check("add_u0", d_res[0], 72'h2C21160B);
        check("add_u1", d_res[1], 72'h2C21160B);
        check("add_ovf", 72'(if0.overflow), 72'd0);

        set2(200, 2, 3, 4, 100, 20, 30, 40);
        go(0, 0, 0, 4);
        check("addwrap_u0", d_res[0], 72'h2C21162C);
        check("addclamp_u1", d_res[1], 72'h2C2116FF);
        check("addwrap_ovf", 72'(if0.overflow), 72'd1);
        check("addclamp_ovf", 72'(if1.overflow), 72'd1);

        set2(50, 40, 30, 5, 10, 20, 30, 9);
        go(0, 1, 0, 4);
        check("subwrap_u0", d_res[0], 72'hFC001428);
        check("subclamp_u1", d_res[1], 72'h00001428);
        check("sub_ovf", 72'(if1.overflow), 72'd1);

        for (int k = 0; k < 9; k++) s3_a[8*k +: 8] = 8'(k + 1);
        s3_b = {9{8'hAA}};
        go(1, 2, 0, 9);
        check("transpose_u3", d_res[2], 72'h090603080502070401);
        check("transpose_ovf", 72'(if3.overflow), 72'd0);

        set2(16, 2, 0, 255, 0, 0, 0, 0);
        go(0, 3, 16, 4);
        check("scalewrap_u0", d_res[0], 72'hF0002000);
        check("scaleclamp_u1", d_res[1], 72'hFF0020FF);
        check("scale_ovf", 72'(if0.overflow), 72'd1);

        // Start pulsed mid-run must be ignored
        set2(1, 2, 3, 4, 10, 20, 30, 40);
        s2_op = 2'd0; s2_start = 1'b1;
        @(posedge clk); #1 s2_start = 1'b0;
        @(posedge clk); #1;
        set2(9, 9, 9, 9, 1, 1, 1, 1);
        s2_op = 2'd1; s2_start = 1'b1;
        @(posedge clk); #1 s2_start = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (if0.done) dones++;
        end
        check("ignored_start_dones", 72'(dones), 72'd1);
        check("ignored_start_result", d_res[0], 72'h2C21160B);

        // Reset during the second RUN cycle aborts the operation
        set2(16, 2, 0, 255, 0, 0, 0, 0);
        s2_op = 2'd3; s2_sc = 8'd16; s2_start = 1'b1;
        @(posedge clk); #1 s2_start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_busy",   72'(if0.busy), 72'd0);
        check("abort_done",   72'(if0.done), 72'd0);
        check("abort_result", d_res[0], 72'd0);
        check("abort_ovf",    72'(if0.overflow), 72'd0);

        set2(1, 2, 3, 4, 10, 20, 30, 40);
        go(0, 0, 0, 4);
        check("after_abort_add", d_res[0], 72'h2C21160B);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
